// File: rtl/hf_14a_tag_frame_decoder_pkg.sv
// Shared HF definitions: ISO14443-A sequence codes, frame status codes,
// FPGA major-mode constants and the decoder's default parameters.
// Ports: none (package).
package hf_14a_tag_frame_decoder_pkg;

  // Default decoder geometry at 106 kbit/s: one mod sample per 16 carrier
  // clocks, 64 carrier clocks per Manchester half-bit.
  localparam int SAMPLES_PER_HALF_DEF = 4;
  localparam int HALF_THRESH_DEF      = 2;
  localparam int MAX_BYTES_DEF        = 32;

  // HF ISO14443-A major modes as driven by the ARM.
  typedef enum logic [2:0] {
    MODE_SNIFFER       = 3'd0,
    MODE_TAGSIM_LISTEN = 3'd1,
    MODE_TAGSIM_MOD    = 3'd2,
    MODE_READER_LISTEN = 3'd3,
    MODE_READER_MOD    = 3'd4
  } major_mode_e;

  // Tag->reader symbols, encoded as {first half modulated, second half modulated}.
  typedef enum logic [1:0] {
    SEQ_F    = 2'b00,   // no modulation: end of frame
    SEQ_E    = 2'b01,   // logic 0
    SEQ_D    = 2'b10,   // logic 1
    SEQ_COLL = 2'b11    // both halves: two tags disagree
  } seq_e;

  typedef enum logic [1:0] {
    FS_OK       = 2'b00,
    FS_OVERFLOW = 2'b01,
    FS_ABORT    = 2'b10,
    FS_FRAMING  = 2'b11
  } frame_status_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SOF_H1  = 3'd1,
    ST_SOF_H2  = 3'd2,
    ST_DATA_H1 = 3'd3,
    ST_DATA_H2 = 3'd4
  } dec_state_e;

  // Data value carried by a symbol; a collision reads as 1.
  function automatic logic seq_bit(input seq_e s);
    return (s == SEQ_D) || (s == SEQ_COLL);
  endfunction

endpackage

// File: rtl/hf_14a_tag_frame_decoder_if.sv
// Bundle between the reader-listen front end and the tag frame decoder.
// master: front end side (drives enable/sample_stb/mod_in, consumes results).
// slave : decoder side (consumes samples, drives frame/byte results).
interface hf_14a_tag_frame_decoder_if;
  logic       enable;
  logic       sample_stb;
  logic       mod_in;
  logic       frame_start;
  logic [7:0] byte_out;
  logic [3:0] byte_nbits;
  logic       byte_valid;
  logic       parity_err;
  logic       coll_seen;
  logic       frame_end;
  logic [1:0] frame_status;
  logic       busy;

  modport master (
    output enable, sample_stb, mod_in,
    input  frame_start, byte_out, byte_nbits, byte_valid, parity_err,
           coll_seen, frame_end, frame_status, busy
  );

  modport slave (
    input  enable, sample_stb, mod_in,
    output frame_start, byte_out, byte_nbits, byte_valid, parity_err,
           coll_seen, frame_end, frame_status, busy
  );
endinterface

// File: rtl/hf_14a_halfbit_integrator.sv
// Counts mod samples over one Manchester half-bit and votes on the result.
// Ports: clk (negedge), reset (sync, active-high), sample_en, phase_rst, mod_in;
//        half_done/half_mod are combinational and valid on the closing sample.
module hf_14a_halfbit_integrator #(
  parameter int SAMPLES_PER_HALF = 4,
  parameter int HALF_THRESH      = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sample_en,
  input  logic phase_rst,
  input  logic mod_in,
  output logic half_done,
  output logic half_mod
);

  localparam int CW = (SAMPLES_PER_HALF > 1) ? $clog2(SAMPLES_PER_HALF) : 1;
  localparam int AW = $clog2(SAMPLES_PER_HALF + 1);
  localparam logic [CW-1:0] LAST = CW'(SAMPLES_PER_HALF - 1);

  logic [CW-1:0] cnt;
  logic [AW-1:0] acc;
  logic [AW-1:0] acc_next;

  // Include the current sample so the vote is ready on the closing strobe.
  assign acc_next  = acc + AW'(mod_in);
  assign half_done = sample_en && !phase_rst && (cnt == LAST);
  assign half_mod  = (acc_next >= AW'(HALF_THRESH));

  always_ff @(negedge clk) begin
    if (reset) begin
      cnt <= '0;
      acc <= '0;
    end else if (sample_en) begin
      if (phase_rst) begin
        // The triggering sample is sample 0 of a new half.
        cnt <= CW'(1);
        acc <= AW'(mod_in);
      end else if (cnt == LAST) begin
        cnt <= '0;
        acc <= '0;
      end else begin
        cnt <= cnt + CW'(1);
        acc <= acc_next;
      end
    end
  end

endmodule

// File: rtl/hf_14a_tag_frame_decoder.sv
// Decodes ISO14443-A 106 kbit/s tag responses into SOF / byte / EOF events.
// Ports: ck_1356meg (all logic on negedge), reset (sync, active-high),
//        bus (slave): enable/sample_stb/mod_in in; frame and byte results out.
module hf_14a_tag_frame_decoder
  import hf_14a_tag_frame_decoder_pkg::*;
#(
  parameter int SAMPLES_PER_HALF = SAMPLES_PER_HALF_DEF,
  parameter int HALF_THRESH      = HALF_THRESH_DEF,
  parameter int MAX_BYTES        = MAX_BYTES_DEF
) (
  input  logic                        ck_1356meg,
  input  logic                        reset,
  hf_14a_tag_frame_decoder_if.slave   bus
);

  localparam int BCW = $clog2(MAX_BYTES + 1);
  localparam logic [BCW-1:0] BYTE_LIMIT = BCW'(MAX_BYTES);

  logic sample_en;
  logic phase_rst;
  logic half_done;
  logic half_mod;

  dec_state_e    state;
  logic          h1;            // first half of the symbol in flight
  logic [7:0]    data;
  logic [3:0]    bit_cnt;       // 0..7 data bits, 8 = expecting parity
  logic          par_acc;       // XOR of data bits so far
  logic          coll_acc;
  logic [BCW-1:0] byte_cnt;     // full bytes emitted this frame

  // Holds a frame_end that must follow a byte_valid by one cycle.
  logic          end_pend;
  frame_status_e end_pend_status;

  logic          frame_start_q;
  logic [7:0]    byte_out_q;
  logic [3:0]    byte_nbits_q;
  logic          byte_valid_q;
  logic          parity_err_q;
  logic          coll_seen_q;
  logic          frame_end_q;
  frame_status_e frame_status_q;
  logic          busy_q;

  seq_e sym;
  logic sym_bit;
  logic sym_coll;

  assign sample_en = bus.sample_stb && bus.enable;
  assign phase_rst = (state == ST_IDLE) && sample_en && bus.mod_in;

  assign sym      = seq_e'({h1, half_mod});
  assign sym_bit  = seq_bit(sym);
  assign sym_coll = (sym == SEQ_COLL);

  hf_14a_halfbit_integrator #(
    .SAMPLES_PER_HALF (SAMPLES_PER_HALF),
    .HALF_THRESH      (HALF_THRESH)
  ) u_integrator (
    .clk       (ck_1356meg),
    .reset     (reset),
    .sample_en (sample_en),
    .phase_rst (phase_rst),
    .mod_in    (bus.mod_in),
    .half_done (half_done),
    .half_mod  (half_mod)
  );

  always_ff @(negedge ck_1356meg) begin
    if (reset) begin
      state           <= ST_IDLE;
      h1              <= 1'b0;
      data            <= '0;
      bit_cnt         <= '0;
      par_acc         <= 1'b0;
      coll_acc        <= 1'b0;
      byte_cnt        <= '0;
      end_pend        <= 1'b0;
      end_pend_status <= FS_OK;
      frame_start_q   <= 1'b0;
      byte_out_q      <= '0;
      byte_nbits_q    <= '0;
      byte_valid_q    <= 1'b0;
      parity_err_q    <= 1'b0;
      coll_seen_q     <= 1'b0;
      frame_end_q     <= 1'b0;
      frame_status_q  <= FS_OK;
      busy_q          <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      byte_valid_q  <= 1'b0;
      frame_end_q   <= 1'b0;

      // A pending end is only ever set on the way to IDLE, so it cannot
      // collide with another result pulse.
      if (end_pend) begin
        frame_end_q    <= 1'b1;
        frame_status_q <= end_pend_status;
        end_pend       <= 1'b0;
        busy_q         <= 1'b0;
      end

      if (state != ST_IDLE && !bus.enable) begin
        // Mode switched away mid-frame: drop any partial byte.
        frame_end_q    <= 1'b1;
        frame_status_q <= FS_ABORT;
        busy_q         <= 1'b0;
        state          <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (sample_en && bus.mod_in) begin
              state  <= ST_SOF_H1;
              busy_q <= 1'b1;
            end
          end

          ST_SOF_H1: begin
            if (half_done) begin
              if (half_mod) begin
                state <= ST_SOF_H2;
              end else begin
                // Isolated spike: silently return to hunting.
                state  <= ST_IDLE;
                busy_q <= 1'b0;
              end
            end
          end

          ST_SOF_H2: begin
            if (half_done) begin
              if (!half_mod) begin
                frame_start_q <= 1'b1;
                state         <= ST_DATA_H1;
                data          <= '0;
                bit_cnt       <= '0;
                par_acc       <= 1'b0;
                coll_acc      <= 1'b0;
                byte_cnt      <= '0;
              end else begin
                frame_end_q    <= 1'b1;
                frame_status_q <= FS_FRAMING;
                busy_q         <= 1'b0;
                state          <= ST_IDLE;
              end
            end
          end

          ST_DATA_H1: begin
            if (half_done) begin
              h1    <= half_mod;
              state <= ST_DATA_H2;
            end
          end

          ST_DATA_H2: begin
            if (half_done) begin
              state <= ST_DATA_H1;
              if (sym == SEQ_F) begin
                state <= ST_IDLE;
                if (bit_cnt == 4'd0) begin
                  frame_end_q    <= 1'b1;
                  frame_status_q <= FS_OK;
                  busy_q         <= 1'b0;
                end else begin
                  // Trailing short byte, or a full byte whose parity
                  // never arrived; the end follows next cycle.
                  byte_valid_q    <= 1'b1;
                  byte_out_q      <= data;
                  byte_nbits_q    <= bit_cnt;
                  parity_err_q    <= (bit_cnt == 4'd8);
                  coll_seen_q     <= coll_acc;
                  end_pend        <= 1'b1;
                  end_pend_status <= (bit_cnt == 4'd8) ? FS_FRAMING : FS_OK;
                end
              end else if (byte_cnt == BYTE_LIMIT) begin
                frame_end_q    <= 1'b1;
                frame_status_q <= FS_OVERFLOW;
                busy_q         <= 1'b0;
                state          <= ST_IDLE;
              end else if (bit_cnt == 4'd8) begin
                // Parity bit closes the byte; odd parity over 9 bits is good.
                byte_valid_q <= 1'b1;
                byte_out_q   <= data;
                byte_nbits_q <= 4'd8;
                parity_err_q <= ~(par_acc ^ sym_bit);
                coll_seen_q  <= coll_acc | sym_coll;
                // The limit check above keeps this from passing MAX_BYTES.
                byte_cnt     <= byte_cnt + BCW'(1);
                bit_cnt      <= '0;
                data         <= '0;
                par_acc      <= 1'b0;
                coll_acc     <= 1'b0;
              end else begin
                data[bit_cnt[2:0]] <= sym_bit;
                par_acc            <= par_acc ^ sym_bit;
                coll_acc           <= coll_acc | sym_coll;
                bit_cnt            <= bit_cnt + 4'd1;
              end
            end
          end

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.frame_start  = frame_start_q;
  assign bus.byte_out     = byte_out_q;
  assign bus.byte_nbits   = byte_nbits_q;
  assign bus.byte_valid   = byte_valid_q;
  assign bus.parity_err   = parity_err_q;
  assign bus.coll_seen    = coll_seen_q;
  assign bus.frame_end    = frame_end_q;
  assign bus.frame_status = frame_status_q;
  assign bus.busy         = busy_q;

endmodule
